dram_array_ctrl: RTL and testbench

//  Parametrised multi-bank DRAM emulation with a multiplexed row/column address and a parity bit per word.

---
 rtl/dram_array_ctrl_pkg.sv | 20 ++
 rtl/dram_array_ctrl_store.sv | 31 +++
 rtl/dram_array_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dram_array_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_array_ctrl_pkg.sv
// Shared definitions for the multi-bank DRAM array emulation: FSM encoding,
// default geometry and a bank-index width helper.
package dram_array_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        ACCESS  = 2'd2,
        REFRESH = 2'd3
    } state_t;

    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned AW_DEF    = 8;
    localparam int unsigned BANKS_DEF = 4;

    function automatic int unsigned bank_bits(input int unsigned banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/dram_array_ctrl_store.sv
// Word storage for all banks: synchronous single-port RAM, one-cycle read,
// read register only updates on an enabled read.
module dram_store
    import dram_array_ctrl_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned BANKS = BANKS_DEF,
    localparam int unsigned BW     = bank_bits(BANKS),
    localparam int unsigned ADDR_W = BW + 2 * AW
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DW:0]       wdata,
    output logic [DW:0]       rdata
);

    localparam int unsigned DEPTH = BANKS << (2 * AW);

    logic [DW:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/dram_array_ctrl.sv
// RAS/CAS-strobed multi-bank DRAM emulation with page mode and CBR refresh.
// Optional read parity checking (odd parity) is enabled by PARITY_CHK_EN.
module dram_array_ctrl
    import dram_array_ctrl_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned BANKS = BANKS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ma,
    input  logic [BANKS-1:0] ras_n,
    input  logic             cas_n,
    input  logic             we_n,
    input  logic [DW-1:0]    md_in,
    input  logic             mdp_in,
    output logic [DW-1:0]    md_out,
    output logic             mdp_out,
    output logic             md_oe,
    output logic [AW-1:0]    ref_row,
    output logic             conflict
`ifdef PARITY_CHK_EN
    ,output logic            par_err
`endif
);

    localparam int unsigned BW = bank_bits(BANKS);

    state_t state, state_nxt;

    logic [BANKS-1:0] ras_q, ras_fall, ras_rise, bank_mask;
    logic             cas_q, cas_fall, cas_rise;
    logic             act_rise, other_fall, multi_fall;
    logic [BW-1:0]    fall_sel, bank;
    logic [AW-1:0]    row, col;
    logic             rd_cycle;

    logic             mem_en, mem_we;
    logic [BW+2*AW-1:0] mem_addr;
    logic [DW:0]      rdata;
    logic             row_load, bank_load, col_load, ref_inc;
    logic             conflict_set, oe_nxt, rd_set, rd_clr;

    always_comb begin
        ras_fall  = ras_q & ~ras_n;
        ras_rise  = ~ras_q & ras_n;
        cas_fall  = cas_q & ~cas_n;
        cas_rise  = ~cas_q & cas_n;
        bank_mask = '0;
        bank_mask[bank] = 1'b1;
        act_rise   = |(ras_rise & bank_mask);
        other_fall = |(ras_fall & ~bank_mask);
        multi_fall = |(ras_fall & (ras_fall - BANKS'(1)));
        fall_sel   = '0;
        for (int unsigned i = BANKS; i > 0; i--) begin
            if (ras_fall[i-1]) fall_sel = BW'(i - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|ras_fall) state_nxt = cas_n ? ACTIVE : REFRESH;
            ACTIVE:  if (act_rise)  state_nxt = IDLE;
                     else if (cas_fall) state_nxt = ACCESS;
            ACCESS:  if (act_rise)  state_nxt = IDLE;
                     else if (cas_rise) state_nxt = ACTIVE;
            REFRESH: if (act_rise)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        row_load     = 1'b0;
        bank_load    = 1'b0;
        col_load     = 1'b0;
        ref_inc      = 1'b0;
        conflict_set = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        oe_nxt       = 1'b0;
        rd_set       = 1'b0;
        rd_clr       = 1'b0;
        case (state)
            IDLE: begin
                bank_load    = |ras_fall;
                row_load     = (|ras_fall) & cas_n;
                ref_inc      = (|ras_fall) & ~cas_n;
                conflict_set = multi_fall;
            end
            ACTIVE: begin
                conflict_set = other_fall;
                if (!act_rise && cas_fall) begin
                    col_load = 1'b1;
                    mem_en   = 1'b1;
                    mem_we   = ~we_n;
                    rd_set   = we_n;
                end
            end
            ACCESS: begin
                conflict_set = other_fall;
                if (!act_rise && !cas_rise) begin
                    if (!we_n) rd_clr = 1'b1;
                    else       oe_nxt = rd_cycle;
                end
            end
            default: ;
        endcase
        // Reset mid-access must never reach storage.
        mem_en   = mem_en & rst_n;
        mem_we   = mem_we & rst_n;
        mem_addr = {bank, row, col_load ? ma : col};
    end

    // Strobe history tracks the pins even during reset, so a RAS held low
    // across reset is not seen as a fresh fall afterwards.
    always_ff @(posedge clk) begin
        ras_q <= ras_n;
        cas_q <= cas_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row      <= '0;
            col      <= '0;
            bank     <= '0;
            md_out   <= '0;
            mdp_out  <= 1'b0;
            md_oe    <= 1'b0;
            ref_row  <= '0;
            conflict <= 1'b0;
            rd_cycle <= 1'b0;
        end else begin
            if (row_load)     row      <= ma;
            if (bank_load)    bank     <= fall_sel;
            if (col_load)     col      <= ma;
            if (ref_inc)      ref_row  <= ref_row + AW'(1);
            if (conflict_set) conflict <= 1'b1;
            if (col_load)     rd_cycle <= rd_set;
            else if (rd_clr)  rd_cycle <= 1'b0;
            md_oe <= oe_nxt;
            if (oe_nxt) {mdp_out, md_out} <= rdata;
        end
    end

`ifdef PARITY_CHK_EN
    // Checked once per read, on the edge where data first becomes valid.
    always_ff @(posedge clk) begin
        if (!rst_n) par_err <= 1'b0;
        else        par_err <= oe_nxt & ~md_oe & ~(^rdata);
    end
`endif

    dram_store #(
        .DW    (DW),
        .AW    (AW),
        .BANKS (BANKS)
    ) u_store (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata ({mdp_in, md_in}),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dram_array_ctrl.sv
// Self-checking bench for dram_array_ctrl: directed scenarios plus randomized
// page-mode traffic against an associative-array memory model.
module tb_dram_array_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned BANKS = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    ma;
    logic [BANKS-1:0] ras_n;
    logic             cas_n, we_n, mdp_in;
    logic [DW-1:0]    md_in, md_out;
    logic             mdp_out, md_oe, conflict;
    logic [AW-1:0]    ref_row;
`ifdef PARITY_CHK_EN
    logic             par_err;
`endif

    always #5 clk = ~clk;

    dram_array_ctrl #(.DW(DW), .AW(AW), .BANKS(BANKS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ma       (ma),
        .ras_n    (ras_n),
        .cas_n    (cas_n),
        .we_n     (we_n),
        .md_in    (md_in),
        .mdp_in   (mdp_in),
        .md_out   (md_out),
        .mdp_out  (mdp_out),
        .md_oe    (md_oe),
        .ref_row  (ref_row),
        .conflict (conflict)
`ifdef PARITY_CHK_EN
        ,.par_err (par_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [DW:0]   model [int];
    logic [AW-1:0] ref_m;
    logic          conflict_m;

    function automatic int key(input int b, input logic [AW-1:0] r, input logic [AW-1:0] c);
        return (b << (2 * AW)) | (int'(r) << AW) | int'(c);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        ras_n = '1; cas_n = 1'b1; we_n = 1'b1;
        ma = '0; md_in = '0; mdp_in = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle_bus();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        ref_m = '0;
        conflict_m = 1'b0;
    endtask

    task automatic ras_open(input int b, input logic [AW-1:0] r);
        ma = r; ras_n = '1; ras_n[b] = 1'b0;
        tick();
    endtask

    task automatic ras_close;
        ras_n = '1; cas_n = 1'b1; we_n = 1'b1;
        tick();
    endtask

    task automatic cas_write(input logic [AW-1:0] c, input logic [DW:0] d, output logic oe_seen);
        ma = c; we_n = 1'b0; {mdp_in, md_in} = d; cas_n = 1'b0;
        tick();
        oe_seen = md_oe;
        cas_n = 1'b1; we_n = 1'b1;
        tick();
        oe_seen = oe_seen | md_oe;
    endtask

    // Observes one read cycle: md_oe must be low one edge after the CAS fall,
    // high with stable data while CAS is held, and low (data held) after CAS rises.
    task automatic cas_read(input logic [AW-1:0] c, input int hold,
                            output logic [DW:0] obs, output logic timing_ok);
        ma = c; we_n = 1'b1; cas_n = 1'b0;
        tick();
        timing_ok = (md_oe === 1'b0);
        tick();
        timing_ok = timing_ok & (md_oe === 1'b1);
        obs = {mdp_out, md_out};
        repeat (hold) begin
            tick();
            timing_ok = timing_ok & (md_oe === 1'b1) & ({mdp_out, md_out} === obs);
        end
        cas_n = 1'b1;
        tick();
        timing_ok = timing_ok & (md_oe === 1'b0) & ({mdp_out, md_out} === obs);
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (md_out !== '0) begin errors++; $display("FAIL reset_md_out got %h want 00", md_out); end
        checks++; if (mdp_out !== 1'b0) begin errors++; $display("FAIL reset_mdp_out got %b want 0", mdp_out); end
        checks++; if (md_oe !== 1'b0) begin errors++; $display("FAIL reset_md_oe got %b want 0", md_oe); end
        checks++; if (ref_row !== ref_m) begin errors++; $display("FAIL reset_ref_row got %h want %h", ref_row, ref_m); end
        checks++; if (conflict !== conflict_m) begin errors++; $display("FAIL reset_conflict got %b want %b", conflict, conflict_m); end
`ifdef PARITY_CHK_EN
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got %b want 0", par_err); end
`endif
    endtask

    task automatic test_write_read;
        logic oe; logic ok; logic [DW:0] obs;
        ras_open(0, 8'h12);
        cas_write(8'h34, {1'b1, 8'hA5}, oe);
        ras_close();
        model[key(0, 8'h12, 8'h34)] = {1'b1, 8'hA5};
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL wr_md_oe got %b want 0", oe); end
        ras_open(0, 8'h12);
        cas_read(8'h34, 1, obs, ok);
        ras_close();
        checks++; if (obs !== 9'h1A5) begin errors++; $display("FAIL rd_data got %h want 1a5", obs); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_oe_timing got %b want 1", ok); end
    endtask

    task automatic test_page_mode;
        logic oe; logic ok; logic [DW:0] obs, exp_d;
        logic [AW-1:0] r;
        r = AW'($urandom);
        ras_open(2, r);
        for (int i = 0; i < 3; i++) begin
            exp_d = {1'b0, 8'h11 * 8'(i + 1)};
            cas_write(AW'(i), exp_d, oe);
            model[key(2, r, AW'(i))] = exp_d;
            checks++; if (oe !== 1'b0) begin errors++; $display("FAIL page_wr_oe col %0d got %b want 0", i, oe); end
        end
        ras_close();
        ras_open(2, r);
        for (int i = 0; i < 3; i++) begin
            cas_read(AW'(i), i, obs, ok);
            exp_d = {1'b0, 8'h11 * 8'(i + 1)};
            checks++; if (obs !== exp_d) begin errors++; $display("FAIL page_rd col %0d got %h want %h", i, obs, exp_d); end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL page_oe col %0d got %b want 1", i, ok); end
        end
        ras_close();
    endtask

    task automatic test_cbr_refresh;
        int oe_hi; logic ok; logic [DW:0] obs;
        oe_hi = 0;
        for (int n = 0; n < 256; n++) begin
            cas_n = 1'b0; tick(); oe_hi += int'(md_oe);
            ras_n[1] = 1'b0; tick(); oe_hi += int'(md_oe);
            ref_m = ref_m + AW'(1);
            ras_n = '1; tick(); oe_hi += int'(md_oe);
            cas_n = 1'b1; tick(); oe_hi += int'(md_oe);
            checks++; if (ref_row !== ref_m) begin errors++; $display("FAIL cbr_ref_row iter %0d got %h want %h", n, ref_row, ref_m); end
        end
        checks++; if (ref_row !== 8'h00) begin errors++; $display("FAIL cbr_wrap got %h want 00", ref_row); end
        checks++; if (oe_hi !== 0) begin errors++; $display("FAIL cbr_md_oe high_cycles got %0d want 0", oe_hi); end
        ras_open(0, 8'h12);
        cas_read(8'h34, 0, obs, ok);
        ras_close();
        checks++; if (obs !== model[key(0, 8'h12, 8'h34)]) begin errors++; $display("FAIL cbr_mem got %h want %h", obs, model[key(0, 8'h12, 8'h34)]); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cbr_mem_oe got %b want 1", ok); end
    endtask

    task automatic test_conflict;
        logic oe; logic ok; logic [DW:0] obs;
        ras_open(1, 8'h40);
        cas_write(8'h05, 9'h0C3, oe);
        ras_close();
        model[key(1, 8'h40, 8'h05)] = 9'h0C3;
        ma = 8'h40; ras_n = 4'b1100;
        tick();
        conflict_m = 1'b1;
        checks++; if (conflict !== conflict_m) begin errors++; $display("FAIL conflict_set got %b want %b", conflict, conflict_m); end
        cas_write(8'h05, 9'h13C, oe);
        model[key(0, 8'h40, 8'h05)] = 9'h13C;
        ras_close();
        ras_open(0, 8'h40);
        cas_read(8'h05, 0, obs, ok);
        ras_close();
        checks++; if (obs !== 9'h13C) begin errors++; $display("FAIL conflict_bank0 got %h want 13c", obs); end
        ras_open(1, 8'h40);
        cas_read(8'h05, 0, obs, ok);
        ras_close();
        checks++; if (obs !== 9'h0C3) begin errors++; $display("FAIL conflict_bank1 got %h want 0c3", obs); end
        checks++; if (conflict !== conflict_m) begin errors++; $display("FAIL conflict_sticky got %b want %b", conflict, conflict_m); end
        do_reset();
        checks++; if (conflict !== conflict_m) begin errors++; $display("FAIL conflict_clear got %b want %b", conflict, conflict_m); end
    endtask

    task automatic test_reset_mid_write;
        logic oe; logic ok; logic [DW:0] obs;
        ras_open(3, 8'h77);
        cas_write(8'h21, 9'h15A, oe);
        ras_close();
        model[key(3, 8'h77, 8'h21)] = 9'h15A;
        ras_open(3, 8'h77);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ref_m = '0; conflict_m = 1'b0;
        ma = 8'h21; we_n = 1'b0; {mdp_in, md_in} = 9'h0FF; cas_n = 1'b0;
        tick();
        tick();
        checks++; if (md_oe !== 1'b0) begin errors++; $display("FAIL rstmid_md_oe got %b want 0", md_oe); end
        cas_n = 1'b1; we_n = 1'b1;
        tick();
        ras_close();
        ras_open(3, 8'h77);
        cas_read(8'h21, 0, obs, ok);
        ras_close();
        checks++; if (obs !== 9'h15A) begin errors++; $display("FAIL rstmid_old_data got %h want 15a", obs); end
        checks++; if (ref_row !== ref_m) begin errors++; $display("FAIL rstmid_ref_row got %h want %h", ref_row, ref_m); end
    endtask

    task automatic test_ras_wins;
        logic oe; logic ok; logic [DW:0] obs;
        ras_open(0, 8'h99);
        cas_write(8'h0A, 9'h066, oe);
        ras_close();
        model[key(0, 8'h99, 8'h0A)] = 9'h066;
        ras_open(0, 8'h99);
        ras_n = '1; ma = 8'h0A; we_n = 1'b0; {mdp_in, md_in} = 9'h199; cas_n = 1'b0;
        tick();
        cas_n = 1'b1; we_n = 1'b1;
        tick();
        ras_open(0, 8'h99);
        cas_read(8'h0A, 0, obs, ok);
        ras_close();
        checks++; if (obs !== 9'h066) begin errors++; $display("FAIL ras_wins got %h want 066", obs); end
    endtask

    task automatic test_we_mid_read;
        logic oe; logic ok; logic [DW:0] obs;
        ras_open(1, 8'h3C);
        cas_write(8'hE0, 9'h1E7, oe);
        ras_close();
        model[key(1, 8'h3C, 8'hE0)] = 9'h1E7;
        ras_open(1, 8'h3C);
        ma = 8'hE0; we_n = 1'b1; {mdp_in, md_in} = 9'h000; cas_n = 1'b0;
        tick();
        tick();
        checks++; if (md_oe !== 1'b1) begin errors++; $display("FAIL wemid_oe_before got %b want 1", md_oe); end
        we_n = 1'b0;
        tick();
        checks++; if (md_oe !== 1'b0) begin errors++; $display("FAIL wemid_oe_drop got %b want 0", md_oe); end
        we_n = 1'b1; cas_n = 1'b1;
        tick();
        ras_close();
        ras_open(1, 8'h3C);
        cas_read(8'hE0, 0, obs, ok);
        ras_close();
        checks++; if (obs !== 9'h1E7) begin errors++; $display("FAIL wemid_no_write got %h want 1e7", obs); end
    endtask

    task automatic test_random;
        logic oe; logic ok; logic [DW:0] obs, d;
        logic [AW-1:0] r, c;
        int b, k;
        for (int t = 0; t < 50; t++) begin
            b = int'($urandom_range(0, BANKS - 1));
            r = AW'($urandom_range(0, 3) * 64);
            ras_open(b, r);
            for (int op = 0; op < int'($urandom_range(1, 4)); op++) begin
                c = AW'($urandom_range(0, 7));
                k = key(b, r, c);
                if (model.exists(k) && ($urandom_range(0, 1) == 1)) begin
                    cas_read(c, int'($urandom_range(0, 2)), obs, ok);
                    checks++; if (obs !== model[k]) begin errors++; $display("FAIL rand_rd t%0d b%0d r%h c%h got %h want %h", t, b, r, c, obs, model[k]); end
                    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_oe t%0d got %b want 1", t, ok); end
                end else begin
                    d = (DW+1)'($urandom);
                    cas_write(c, d, oe);
                    model[k] = d;
                    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rand_wr_oe t%0d got %b want 0", t, oe); end
                end
            end
            ras_close();
        end
    endtask

`ifdef PARITY_CHK_EN
    task automatic test_parity;
        logic oe;
        logic [2:0] seen;
        for (int p = 1; p >= 0; p--) begin
            ras_open(2, 8'h55);
            cas_write(8'h66, {1'(p), 8'h01}, oe);
            ma = 8'h66; we_n = 1'b1; cas_n = 1'b0;
            tick(); seen[0] = par_err;
            tick(); seen[1] = par_err;
            tick(); seen[2] = par_err;
            cas_n = 1'b1;
            tick();
            ras_close();
            model[key(2, 8'h55, 8'h66)] = {1'(p), 8'h01};
            // Odd parity is violated only when the parity bit makes the total even.
            checks++; if (seen !== ((p == 1) ? 3'b010 : 3'b000)) begin
                errors++; $display("FAIL parity mdp=%0d got %b want %b", p, seen, (p == 1) ? 3'b010 : 3'b000);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        rst_n = 1'b0;
        test_reset();
        test_write_read();
        test_page_mode();
        test_cbr_refresh();
        test_conflict();
        test_reset_mid_write();
        test_ras_wins();
        test_we_mid_read();
        test_random();
`ifdef PARITY_CHK_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
